pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Parametrised successor to the single-register PC: owns the fetch address for the IF stage of the 5-stage RISC-V pipeline.
- Selects next PC by priority: trap vector, then redirect (branch/jump), then sequential increment.
- Holds the request address stable under stall and instruction-memory backpressure, and buffers one late redirect.
- Detects misaligned targets and parks in a fault state until a trap vector arrives.

Parameters:
XLEN, 32, address width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
INC, 4, sequential increment in bytes
ALIGN_BITS, 2, low target bits that must be zero (2 = word aligned; 1 allows compressed instructions)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset; synchronous, active-high (1 = reset), despite the name
clk_en  input  1  clock enable; when 0, all state frozen and inputs ignored
stall  input  1  hazard unit requests the PC hold
redirect_valid  input  1  branch/jump resolved taken this cycle
redirect_target  input  XLEN  target for redirect
trap_valid  input  1  exception/trap entry this cycle
trap_vector  input  XLEN  trap handler address
imem_req_ready  input  1  instruction memory accepts the request this cycle
imem_req_valid  output  1  fetch request valid
pc_out  output  XLEN  current fetch address (the request address)
pc_plus_inc  output  XLEN  pc_out + INC, mod 2^XLEN (combinational)
redirect_pending  output  1  buffered redirect or trap awaiting application
misaligned_fault  output  1  high while in FAULT state

Behaviour:
- Reset (rst_n=1 at a rising edge, overrides clk_en): pc_out=RESET_VECTOR, state=BOOT, imem_req_valid=0, redirect_pending=0, misaligned_fault=0, and the pending buffer is cleared.
- States:
  - BOOT: single cycle; next enabled edge goes to FETCH with pc unchanged.
  - FETCH: imem_req_valid=1.
  - FAULT: imem_req_valid=0, misaligned_fault=1.
- Advance (FETCH only): adv = clk_en & ~stall & imem_req_ready. While valid and not accepted, pc_out must not change (valid-stable rule).
- Next-PC source on an advance edge, highest priority first:
  1. trap_valid, giving trap_vector.
  2. Pending trap in buffer.
  3. redirect_valid, giving redirect_target.
  4. Pending redirect in buffer.
  5. pc_out+INC.
  - The buffer clears when its entry is consumed or overridden by a live input.
- Non-advancing enabled edge in FETCH or BOOT with trap_valid or redirect_valid: capture into the pending buffer.
  - A trap overwrites anything.
  - A redirect overwrites a pending redirect (youngest wins) but never a pending trap.
  - redirect_pending=1 from the next cycle.
- Alignment check on the selected target (trap, redirect or pending): if any of target[ALIGN_BITS-1:0] is non-zero:
  - pc_out still loads the target (visible for the fault cause).
  - state goes to FAULT.
  - Sequential increments are never checked.
- FAULT: ignores stall, imem_req_ready, and redirects (redirects are dropped, not buffered). trap_valid on an enabled edge loads trap_vector and goes to FETCH (or stays in FAULT if trap_vector is itself misaligned).
- Wrap-around: pc_out+INC rolls over at 2^XLEN with no flag.
- Simultaneous trap_valid and redirect_valid: the trap wins and the redirect is discarded.
- clk_en=0: no state change, no capture; outputs hold.
- Latency: a redirect presented on an advancing cycle appears on pc_out after 1 edge.
- Reset mid-stall or in FAULT: returns to BOOT and the buffer is lost.

Test Plan:
1. Sequencing: reset, then ready=1, stall=0 for 4 edges -> pc_out 0 (BOOT), 0, 4, 8, 0xC; imem_req_valid 0 then 1.
2. Backpressure with a late redirect: at pc=0x10, imem_req_ready=0 for 3 cycles, redirect to 0x200 on cycle 1 -> pc_out stays 0x10, redirect_pending=1; first accept gives pc 0x200, pending=0.
3. Priority and overwrite:
   - trap 0x80 and redirect 0x300 on the same advancing edge -> pc 0x80.
   - While stalled: redirect 0x40, then trap 0x90, then redirect 0x44 -> after release pc=0x90.
4. Misaligned redirect: redirect to 0x102 (ALIGN_BITS=2) -> pc_out=0x102, misaligned_fault=1, imem_req_valid=0; redirect 0x400 is ignored; trap 0x1C0 -> FETCH, pc=0x1C0, fault=0.
5. Clock enable and wrap-around:
   - clk_en=0 for 5 cycles with redirect_valid pulsing -> no change and no pending.
   - With XLEN=32 and pc=0xFFFF_FFFC, an advance gives pc_out=0.
6. Reset mid-operation: rst_n=1 while in FAULT with a pending entry -> next cycle pc=RESET_VECTOR, BOOT, all flags 0; reset also applies with clk_en=0.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch-address owner for the IF stage: picks trap/redirect/sequential next PC,
// holds the request under stall/backpressure, buffers one late redirect or trap.
module pc_fetch_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              INC          = 4,
    parameter int              ALIGN_BITS   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_en,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            imem_req_ready,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            redirect_pending,
    output logic            misaligned_fault
);

    // state | meaning
    // BOOT  | one cycle after reset, no request issued
    // FETCH | request valid at pc_out
    // FAULT | misaligned target loaded, waiting for a trap vector
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    state_t          state, state_nx;
    logic [XLEN-1:0] pc, pc_nx;
    logic            pend_valid, pend_valid_nx;
    logic            pend_trap, pend_trap_nx;
    logic [XLEN-1:0] pend_addr, pend_addr_nx;

    logic            adv;
    logic            sel_valid;
    logic [XLEN-1:0] sel_addr;

    function automatic logic is_misaligned(input logic [XLEN-1:0] a);
        return |(a & ALIGN_MASK);
    endfunction

    assign imem_req_valid   = (state == FETCH);
    assign misaligned_fault = (state == FAULT);
    assign redirect_pending = pend_valid;
    assign pc_out           = pc;
    assign pc_plus_inc      = pc + XLEN'(INC);
    assign adv              = (state == FETCH) && !stall && imem_req_ready;

    always_comb begin
        sel_valid = 1'b1;
        sel_addr  = '0;
        if (trap_valid) begin
            sel_addr = trap_vector;
        end else if (pend_valid && pend_trap) begin
            sel_addr = pend_addr;
        end else if (redirect_valid) begin
            sel_addr = redirect_target;
        end else if (pend_valid) begin
            sel_addr = pend_addr;
        end else begin
            sel_valid = 1'b0;
        end
    end

    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        pend_valid_nx = pend_valid;
        pend_trap_nx  = pend_trap;
        pend_addr_nx  = pend_addr;

        case (state)
            BOOT, FETCH: begin
                if (state == BOOT) begin
                    state_nx = FETCH;
                end
                if (adv) begin
                    pend_valid_nx = 1'b0;
                    pend_trap_nx  = 1'b0;
                    if (sel_valid) begin
                        pc_nx = sel_addr;
                        if (is_misaligned(sel_addr)) begin
                            state_nx = FAULT;
                        end
                    end else begin
                        pc_nx = pc_plus_inc;
                    end
                end else if (trap_valid) begin
                    pend_valid_nx = 1'b1;
                    pend_trap_nx  = 1'b1;
                    pend_addr_nx  = trap_vector;
                end else if (redirect_valid && !(pend_valid && pend_trap)) begin
                    // a buffered trap must never be displaced by a redirect
                    pend_valid_nx = 1'b1;
                    pend_trap_nx  = 1'b0;
                    pend_addr_nx  = redirect_target;
                end
            end
            FAULT: begin
                if (trap_valid) begin
                    pc_nx    = trap_vector;
                    state_nx = is_misaligned(trap_vector) ? FAULT : FETCH;
                end
            end
            default: begin
                state_nx = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= BOOT;
            pc         <= RESET_VECTOR;
            pend_valid <= 1'b0;
            pend_trap  <= 1'b0;
            pend_addr  <= '0;
        end else if (clk_en) begin
            state      <= state_nx;
            pc         <= pc_nx;
            pend_valid <= pend_valid_nx;
            pend_trap  <= pend_trap_nx;
            pend_addr  <= pend_addr_nx;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus random traffic, every edge
// compared against a rule-level model of the fetch controller.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic        imem_req_ready;
    logic        imem_req_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_inc;
    logic        redirect_pending;
    logic        misaligned_fault;

    int total = 0;
    int bad   = 0;

    // model: phase 0=boot, 1=fetching, 2=faulted; pend_kind 0=none, 1=redirect, 2=trap
    int          m_phase;
    logic [31:0] m_pc;
    int          pend_kind;
    logic [31:0] pend_addr;

    pc_fetch_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .clk_en           (clk_en),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .trap_valid       (trap_valid),
        .trap_vector      (trap_vector),
        .imem_req_ready   (imem_req_ready),
        .imem_req_valid   (imem_req_valid),
        .pc_out           (pc_out),
        .pc_plus_inc      (pc_plus_inc),
        .redirect_pending (redirect_pending),
        .misaligned_fault (misaligned_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit bad_align(input logic [31:0] a);
        return (a % 4) != 0;
    endfunction

    task automatic model_capture();
        if (trap_valid) begin
            pend_kind = 2;
            pend_addr = trap_vector;
        end else if (redirect_valid && pend_kind != 2) begin
            pend_kind = 1;
            pend_addr = redirect_target;
        end
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        bit          jump;
        if (rst_n) begin
            m_phase   = 0;
            m_pc      = 32'h0;
            pend_kind = 0;
        end else if (clk_en) begin
            if (m_phase == 0) begin
                model_capture();
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (!stall && imem_req_ready) begin
                    jump = 1;
                    tgt  = 0;
                    if (trap_valid)            tgt = trap_vector;
                    else if (pend_kind == 2)   tgt = pend_addr;
                    else if (redirect_valid)   tgt = redirect_target;
                    else if (pend_kind == 1)   tgt = pend_addr;
                    else                       jump = 0;
                    if (jump) begin
                        m_pc = tgt;
                        if (bad_align(tgt)) m_phase = 2;
                    end else begin
                        m_pc = m_pc + 32'd4;
                    end
                    pend_kind = 0;
                end else begin
                    model_capture();
                end
            end else if (trap_valid) begin
                m_pc    = trap_vector;
                m_phase = bad_align(trap_vector) ? 2 : 1;
            end
        end
    endtask

    task automatic check_all();
        chk("pc_out", pc_out, m_pc);
        chk("pc_plus_inc", pc_plus_inc, m_pc + 32'd4);
        chk("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, m_phase == 1});
        chk("misaligned_fault", {31'b0, misaligned_fault}, {31'b0, m_phase == 2});
        chk("redirect_pending", {31'b0, redirect_pending}, {31'b0, pend_kind != 0});
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        rst_n = 0; clk_en = 1; stall = 0; imem_req_ready = 1;
        redirect_valid = 0; redirect_target = 0; trap_valid = 0; trap_vector = 0;
    endtask

    task automatic redir(input logic [31:0] a);
        redirect_valid = 1; redirect_target = a; cyc(); redirect_valid = 0;
    endtask

    task automatic trap(input logic [31:0] a);
        trap_valid = 1; trap_vector = a; cyc(); trap_valid = 0;
    endtask

    initial begin
        m_phase = 0; m_pc = 0; pend_kind = 0; pend_addr = 0;
        idle_inputs();
        rst_n = 1;
        @(posedge clk); model_edge();
        cyc();
        rst_n = 0;
        chk("reset_pc", pc_out, 32'h0);
        chk("reset_valid", {31'b0, imem_req_valid}, 32'd0);

        // sequencing
        cyc(); chk("seq0", pc_out, 32'h0); chk("seq_valid", {31'b0, imem_req_valid}, 32'd1);
        cyc(); chk("seq4", pc_out, 32'h4);
        cyc(); chk("seq8", pc_out, 32'h8);
        cyc(); chk("seqC", pc_out, 32'hC);
        cyc(); chk("seq10", pc_out, 32'h10);

        // backpressure with late redirect
        imem_req_ready = 0;
        redir(32'h200);
        cyc(); cyc();
        chk("bp_hold", pc_out, 32'h10);
        chk("bp_pend", {31'b0, redirect_pending}, 32'd1);
        imem_req_ready = 1;
        cyc();
        chk("bp_apply", pc_out, 32'h200);
        chk("bp_clear", {31'b0, redirect_pending}, 32'd0);

        // trap beats simultaneous redirect
        trap_valid = 1; trap_vector = 32'h80; redirect_valid = 1; redirect_target = 32'h300;
        cyc();
        trap_valid = 0; redirect_valid = 0;
        chk("prio_trap", pc_out, 32'h80);

        // buffered trap is not overwritten by a younger redirect
        stall = 1;
        redir(32'h40);
        trap(32'h90);
        redir(32'h44);
        stall = 0;
        cyc();
        chk("buf_trap_wins", pc_out, 32'h90);

        // misaligned redirect parks in FAULT until a trap
        redir(32'h102);
        chk("mis_pc", pc_out, 32'h102);
        chk("mis_fault", {31'b0, misaligned_fault}, 32'd1);
        redir(32'h400);
        chk("mis_ignore", pc_out, 32'h102);
        chk("mis_nopend", {31'b0, redirect_pending}, 32'd0);
        trap(32'h1C0);
        chk("mis_recover", pc_out, 32'h1C0);
        chk("mis_cleared", {31'b0, misaligned_fault}, 32'd0);

        // clock enable freeze
        clk_en = 0;
        for (int i = 0; i < 5; i++) begin
            redirect_valid = i[0]; redirect_target = 32'h500;
            cyc();
        end
        redirect_valid = 0;
        chk("ce_hold", pc_out, 32'h1C0);
        chk("ce_nopend", {31'b0, redirect_pending}, 32'd0);
        clk_en = 1;

        // wrap-around
        redir(32'hFFFF_FFFC);
        chk("wrap_inc", pc_plus_inc, 32'h0);
        cyc();
        chk("wrap_pc", pc_out, 32'h0);

        // reset from FAULT with clk_en low
        redir(32'h3);
        rst_n = 1; clk_en = 0;
        cyc();
        rst_n = 0; clk_en = 1;
        chk("rst_fault_pc", pc_out, 32'h0);
        chk("rst_fault_flag", {31'b0, misaligned_fault}, 32'd0);

        // reset while stalled with a pending redirect
        cyc();
        stall = 1;
        redir(32'h600);
        chk("pend_before_rst", {31'b0, redirect_pending}, 32'd1);
        rst_n = 1;
        cyc();
        rst_n = 0; stall = 0;
        chk("rst_pend_lost", {31'b0, redirect_pending}, 32'd0);
        chk("rst_boot_valid", {31'b0, imem_req_valid}, 32'd0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n          = ($urandom_range(0, 199) == 0);
            clk_en         = ($urandom_range(0, 9) != 0);
            stall          = ($urandom_range(0, 4) == 0);
            imem_req_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 99) < 15);
            trap_valid     = ($urandom_range(0, 99) < 6);
            redirect_target = ($urandom() & 32'hFFFF_FFFC)
                              | (($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            trap_vector     = ($urandom() & 32'hFFFF_FFFC)
                              | (($urandom_range(0, 19) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
